// File: rtl/fet_align_q.sv
// Instruction fetch queue and aligner: word requests in, one 32/16-bit instruction per cycle out.
// Compressed (RV32C) support is compiled in when FET_RV16_EN is defined.
module fet_align_q #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        fet_flush,
  input  logic [31:0] flush_pc,
  input  logic        fet_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fet_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] rv32_instr_todec,
  output logic        fe2de_rv16
);

  localparam int Cap  = 2 * int'(FQ_DEPTH);
  localparam int CntW = $clog2(Cap + 1);

`ifdef FET_RV16_EN
  localparam bit Rv16 = 1'b1;
`else
  localparam bit Rv16 = 1'b0;
`endif

  logic [15:0]     hq_q [Cap];
  logic [15:0]     hq_d [Cap];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            outst_q, outst_d;
  logic            drop_q, drop_d;
  logic            skip_lo_q, skip_lo_d;

  logic        is32, consume, resp, push_en;
  logic [15:0] push_lo, push_hi;
  int          n_pop, n_push, base;
  logic        unused_flush;

  // Bit 0 of the redirect target is never meaningful; bit 1 only with compressed support.
  assign unused_flush = ^flush_pc[1:0];

  assign resp      = imem_rvalid & outst_q;
  assign imem_req  = cpurst_n & ~outst_q & (cnt_q <= CntW'(Cap - 2)) & ~fet_flush;
  assign imem_addr = req_pc_q;
  assign fetch_pc  = fetch_pc_q;

  always_comb begin
    is32             = ~Rv16 | (hq_q[0][1:0] == 2'b11);
    fet_valid        = is32 ? (cnt_q >= CntW'(2)) : (cnt_q >= CntW'(1));
    rv32_instr_todec = 32'h0000_0013;
    fe2de_rv16       = 1'b0;
    if (fet_valid) begin
      rv32_instr_todec = is32 ? {hq_q[1], hq_q[0]} : {16'h0000, hq_q[0]};
      fe2de_rv16       = ~is32;
    end
  end

  always_comb begin
    consume = fet_valid & ~fet_stall & ~fet_flush;
    n_pop   = consume ? (is32 ? 2 : 1) : 0;
    push_en = resp & ~drop_q & ~fet_flush;
    if (Rv16 && skip_lo_q) begin
      n_push  = 1;
      push_lo = imem_rdata[31:16];
      push_hi = imem_rdata[31:16];
    end else begin
      n_push  = 2;
      push_lo = imem_rdata[15:0];
      push_hi = imem_rdata[31:16];
    end
    if (!push_en) n_push = 0;
    base = int'(cnt_q) - n_pop;

    for (int i = 0; i < Cap; i++) hq_d[i] = hq_q[i];
    if (n_pop == 1) begin
      for (int i = 0; i < Cap - 1; i++) hq_d[i] = hq_q[i + 1];
    end else if (n_pop == 2) begin
      for (int i = 0; i < Cap - 2; i++) hq_d[i] = hq_q[i + 2];
    end
    // Incoming halfwords land right behind the survivors of this cycle's pop.
    for (int i = 0; i < Cap; i++) begin
      if (n_push >= 1 && i == base) hq_d[i] = push_lo;
      if (n_push == 2 && i == base + 1) hq_d[i] = push_hi;
    end

    cnt_d      = CntW'(int'(cnt_q) - n_pop + n_push);
    fetch_pc_d = fetch_pc_q + 32'(2 * n_pop);
    req_pc_d   = imem_req ? req_pc_q + 32'd4 : req_pc_q;
    outst_d    = resp ? 1'b0 : (imem_req ? 1'b1 : outst_q);
    drop_d     = (resp & drop_q) ? 1'b0 : drop_q;
    skip_lo_d  = push_en ? 1'b0 : skip_lo_q;

    if (fet_flush) begin
      cnt_d      = '0;
      fetch_pc_d = Rv16 ? {flush_pc[31:1], 1'b0} : {flush_pc[31:2], 2'b00};
      req_pc_d   = {flush_pc[31:2], 2'b00};
      skip_lo_d  = Rv16 & flush_pc[1];
      // A response racing the flush is stale; one still in flight must be dropped later.
      drop_d     = outst_q & ~imem_rvalid;
      outst_d    = outst_q & ~imem_rvalid;
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      for (int i = 0; i < Cap; i++) hq_q[i] <= '0;
      cnt_q      <= '0;
      req_pc_q   <= {RESET_PC[31:2], 2'b00};
      fetch_pc_q <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      skip_lo_q  <= Rv16 & RESET_PC[1];
    end else begin
      for (int i = 0; i < Cap; i++) hq_q[i] <= hq_d[i];
      cnt_q      <= cnt_d;
      req_pc_q   <= req_pc_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      skip_lo_q  <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_fet_align_q.sv
// Bench for fet_align_q: directed scenarios plus random stall/flush/latency against a
// PC-walk reference model of the instruction stream held in a small memory.
module tb_fet_align_q;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FET_RV16_EN
  localparam bit RV16 = 1'b1;
`else
  localparam bit RV16 = 1'b0;
`endif

  logic        clk, cpurst_n, fet_flush, fet_stall, imem_req, imem_rvalid;
  logic        fet_valid, fe2de_rv16;
  logic [31:0] flush_pc, imem_addr, imem_rdata, fetch_pc, rv32_instr_todec;

  fet_align_q #(.RESET_PC(RST_PC), .FQ_DEPTH(2)) dut (
    .clk              (clk),
    .cpurst_n         (cpurst_n),
    .fet_flush        (fet_flush),
    .flush_pc         (flush_pc),
    .fet_stall        (fet_stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .fet_valid        (fet_valid),
    .fetch_pc         (fetch_pc),
    .rv32_instr_todec (rv32_instr_todec),
    .fe2de_rv16       (fe2de_rv16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0;
  bit          pend = 0;
  int          lat = 0;
  logic [31:0] pend_addr = '0;
  int          maxlat = 0, stall_pct = 0, flush_pct = 0;
  bit          force_stall = 0, force_flush = 0, release_next = 0, inject_stray = 0;
  logic [31:0] flush_target = '0;
  logic [31:0] exp_pc = RST_PC;
  bit          prev_hold = 0;
  logic [31:0] prev_pc, prev_instr;
  logic [31:0] log_pc [$];
  logic [31:0] log_instr [$];
  logic [31:0] log_rv16 [$];
  logic [31:0] req_log [$];
  int          req_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Walks the program image: what instruction starts at pc and how long it is.
  function automatic void ref_instr(input logic [31:0] pc, output logic [31:0] ins,
                                    output logic c, output int len);
    logic [15:0] h;
    h = hw_at(pc);
    if (RV16 && h[1:0] != 2'b11) begin
      ins = {16'h0000, h};
      c   = 1'b1;
      len = 2;
    end else begin
      ins = {hw_at(pc + 32'd2), h};
      c   = 1'b0;
      len = 4;
    end
  endfunction

  task automatic step();
    logic [31:0] e_ins;
    logic        e_c;
    int          e_len;
    @(negedge clk);
    if (release_next) begin
      cpurst_n     = 1'b1;
      release_next = 0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[pend_addr[7:2]];
        pend        = 0;
      end else begin
        lat--;
      end
    end else if (inject_stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hdead_beef;
    end
    inject_stray = 0;
    fet_stall = force_stall || ($urandom_range(99) < stall_pct);
    fet_flush = 1'b0;
    if (force_flush) begin
      fet_flush = 1'b1;
      flush_pc  = flush_target;
    end else if ($urandom_range(99) < flush_pct) begin
      fet_flush = 1'b1;
      flush_pc  = 32'($urandom_range(0, 255));
    end
    force_flush = 0;
    #1;
    if (prev_hold) begin
      chk("hold_valid", {31'b0, fet_valid}, 32'd1);
      chk("hold_pc", fetch_pc, prev_pc);
      chk("hold_instr", rv32_instr_todec, prev_instr);
    end
    if (!fet_valid) begin
      chk("idle_nop", rv32_instr_todec, 32'h0000_0013);
      chk("idle_rv16", {31'b0, fe2de_rv16}, 32'd0);
    end else if (!fet_stall && !fet_flush) begin
      ref_instr(exp_pc, e_ins, e_c, e_len);
      chk("pc", fetch_pc, exp_pc);
      chk("instr", rv32_instr_todec, e_ins);
      chk("rv16", {31'b0, fe2de_rv16}, {31'b0, e_c});
      log_pc.push_back(fetch_pc);
      log_instr.push_back(rv32_instr_todec);
      log_rv16.push_back({31'b0, fe2de_rv16});
      exp_pc = exp_pc + 32'(e_len);
    end
    prev_hold  = fet_valid && fet_stall && !fet_flush;
    prev_pc    = fetch_pc;
    prev_instr = rv32_instr_todec;
    if (fet_flush) exp_pc = RV16 ? {flush_pc[31:1], 1'b0} : {flush_pc[31:2], 2'b00};
    if (imem_req) begin
      chk("req_single_aligned", {30'b0, pend, imem_addr[1]|imem_addr[0]}, 32'd0);
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
      pend      = 1;
      pend_addr = imem_addr;
      lat       = $urandom_range(0, maxlat);
    end
    cyc++;
  endtask

  task automatic do_reset(input bit with_resp);
    @(negedge clk);
    cpurst_n    = 1'b0;
    fet_stall   = 1'b0;
    fet_flush   = 1'b0;
    imem_rvalid = with_resp;
    imem_rdata  = mem[pend_addr[7:2]];
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fet_valid}, 32'd0);
    chk("rst_instr", rv32_instr_todec, 32'h0000_0013);
    chk("rst_rv16", {31'b0, fe2de_rv16}, 32'd0);
    chk("rst_pc", fetch_pc, RST_PC);
    pend = 0; prev_hold = 0; force_stall = 0; force_flush = 0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    log_pc.delete(); log_instr.delete(); log_rv16.delete(); req_log.delete(); req_cyc.delete();
    cyc = 0; exp_pc = RST_PC; release_next = 1;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 64; i++) mem[i] = rnd ? 32'($urandom) : 32'h0000_0013;
  endtask

  initial begin
    int n0, l0, c0, got;
    cpurst_n = 1'b0; fet_flush = 1'b0; fet_stall = 1'b0; flush_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    fill_mem(0);

    // NOP stream at 1-cycle latency
    do_reset(0);
    repeat (12) step();
    chk("t1_first_req_cyc", 32'(req_cyc[0]), 32'd0);
    chk("t1_addr0", req_log[0], 32'h0);
    chk("t1_addr1", req_log[1], 32'h4);
    chk("t1_addr2", req_log[2], 32'h8);
    chk("t1_pc0", log_pc[0], 32'h0);
    chk("t1_pc1", log_pc[1], 32'h4);
    chk("t1_pc2", log_pc[2], 32'h8);
    chk("t1_instr0", log_instr[0], 32'h13);

    // Two compressed instructions in one word
    do_reset(0);
    fill_mem(0);
    mem[0] = 32'h4505_4501;
    maxlat = 1; stall_pct = 20;
    repeat (20) step();
    chk("t2_pc0", log_pc[0], 32'h0);
    chk("t2_instr0", log_instr[0], RV16 ? 32'h4501 : 32'h4505_4501);
    chk("t2_rv16_0", log_rv16[0], {31'b0, RV16});
    chk("t2_pc1", log_pc[1], RV16 ? 32'h2 : 32'h4);
    chk("t2_instr1", log_instr[1], RV16 ? 32'h4505 : 32'h13);

    // Mixed stream with a word-straddling 32-bit instruction
    do_reset(0);
    fill_mem(0);
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h1234_0010;
    repeat (20) step();
    chk("t3_instr0", log_instr[0], RV16 ? 32'h4501 : 32'h0513_4501);
    chk("t3_pc1", log_pc[1], RV16 ? 32'h2 : 32'h4);
    chk("t3_instr1", log_instr[1], RV16 ? 32'h0010_0513 : 32'h1234_0010);
    chk("t3_rv16_1", log_rv16[1], 32'd0);
    chk("t3_pc2", log_pc[2], RV16 ? 32'h6 : 32'h8);
    chk("t3_instr2", log_instr[2], RV16 ? 32'h1234 : 32'h13);

    // Flush to 0x102 with a request in flight
    do_reset(0);
    fill_mem(1);
    maxlat = 0; stall_pct = 0;
    step();
    chk("t4_pending", {31'b0, pend}, 32'd1);
    lat = 2;
    force_flush = 1; flush_target = 32'h102;
    c0 = cyc; n0 = req_log.size(); l0 = log_pc.size();
    repeat (12) step();
    chk("t4_req_addr", req_log[n0], 32'h100);
    chk("t4_req_cyc", 32'(req_cyc[n0]), 32'(c0 + 3));
    chk("t4_first_pc", log_pc[l0], RV16 ? 32'h102 : 32'h100);

    // Stall with a full queue, then flush with nothing in flight
    do_reset(0);
    fill_mem(1);
    repeat (3) step();
    force_stall = 1;
    repeat (4) step();
    n0 = req_log.size();
    repeat (5) step();
    chk("t5_no_req", 32'(req_log.size()), 32'(n0));
    chk("t5_valid", {31'b0, fet_valid}, 32'd1);
    chk("t5_idle", {31'b0, pend}, 32'd0);
    force_flush = 1; flush_target = 32'h40;
    c0 = cyc; n0 = req_log.size();
    step();
    step();
    chk("t5_req_cyc", 32'(req_cyc[n0]), 32'(c0 + 1));
    chk("t5_req_addr", req_log[n0], 32'h40);
    force_stall = 0;
    repeat (30) step();

    // Reset in the middle of a response; a stray response afterwards is ignored
    maxlat = 2; stall_pct = 25;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (pend && lat == 0) got = 1;
    end
    chk("t6_wait", 32'(got), 32'd1);
    do_reset(1);
    inject_stray = 1;
    repeat (30) step();
    chk("t6_req0", req_log[0], RST_PC);

    // Random soak
    do_reset(0);
    fill_mem(1);
    maxlat = 3; stall_pct = 30; flush_pct = 5;
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fet_align_q.md
# fet_align_q

Instruction fetch queue and aligner that produces the per-cycle instruction stream consumed by the fetch→decode pipeline register. It issues word requests to instruction memory, buffers returned words as halfwords, extracts one 32-bit or 16-bit (RV32C) instruction per cycle, and presents it with its PC. It honours the back-pressure (`fet_stall`) and redirect (`fet_flush`) signals coming from the pipeline.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched after reset release.
- `FQ_DEPTH`, 2: queue depth in 32-bit words (legal 2..4); capacity CAP = 2*FQ_DEPTH halfwords.
- `clk`  in  1  clock, all state on rising edge.
- `cpurst_n`  in  1  reset, asynchronous assert, active-low.
- `fet_flush`  in  1  redirect; discard queue and restart at `flush_pc`.
- `flush_pc`  in  32  redirect target, halfword aligned (bit 0 ignored).
- `fet_stall`  in  1  pipeline stall; presented instruction not consumed.
- `imem_req`  out  1  word read request.
- `imem_addr`  out  32  request address, bits[1:0] always 0.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data, little-endian halfwords.
- `fet_valid`  out  1  presented instruction is real.
- `fetch_pc`  out  32  PC of the presented instruction.
- `rv32_instr_todec`  out  32  presented instruction; compressed instructions are zero-extended {16'h0, hw}.
- `fe2de_rv16`  out  1  presented instruction is 16-bit.

## Operation
- State:
  - halfword queue `q[0..CAP-1]` with occupancy `cnt` (0..CAP);
  - `req_pc`, the next word address to request;
  - `fetch_pc`;
  - `outst`, one request outstanding;
  - `drop`, discard the next response;
  - `skip_lo`, discard the low halfword of the next accepted word.
- Request: `imem_req` = ~`outst` & (`cnt` ≤ CAP-2) & ~`fet_flush`. `imem_addr` = `req_pc`.
- On request, set `outst`; `req_pc` += 4.
- Only one request may be outstanding. Response latency is ≥1 cycle and variable.
- Response (`imem_rvalid` & `outst`):
  - clear `outst`;
  - if `drop`: clear `drop` and write nothing;
  - else if `skip_lo`: push `rdata[31:16]` only and clear `skip_lo`;
  - else push `rdata[15:0]` then `rdata[31:16]`.
- `imem_rvalid` with ~`outst` is ignored.
- Extraction from head `q[0]`:
  - if `q[0][1:0]`==2'b11, a 32-bit instruction is available when `cnt`≥2, presented as {q[1],q[0]} with `fe2de_rv16`=0;
  - otherwise a compressed instruction is available when `cnt`≥1, with `fe2de_rv16`=1.
- `fet_valid` = instruction available.
- When ~`fet_valid`: `rv32_instr_todec` = 32'h0000_0013 (NOP) and `fe2de_rv16`=0.
- Consume (`fet_valid` & ~`fet_stall` & ~`fet_flush`): pop 2 or 1 halfwords; `fetch_pc` += 4 or 2. Push and pop may occur in the same cycle; `cnt` updates by the net amount.
- Flush, which has priority over consume and push in the same cycle:
  - `cnt`←0;
  - `fetch_pc`←{`flush_pc`[31:1],1'b0};
  - `req_pc`←{`flush_pc`[31:2],2'b00};
  - `skip_lo`←`flush_pc`[1];
  - `drop`←`outst` & ~`imem_rvalid`.
  - An `imem_rvalid` in the flush cycle is dropped and clears `outst`.
- Reset values:
  - `fetch_pc`=`RESET_PC`, `req_pc`=`RESET_PC`&~3;
  - `cnt`=0; `outst`, `drop`, `imem_req`, `fet_valid`=0;
  - `skip_lo`=`RESET_PC`[1];
  - `rv32_instr_todec`=32'h13; `fe2de_rv16`=0.
- A reset asserted mid-request abandons it. A response arriving after reset release while ~`outst` is ignored.

## Timing
- First `imem_req` in the first cycle after `cpurst_n` deasserts.
- Response in cycle t → instruction visible on the outputs in cycle t+1, because the queue is registered and outputs are decoded combinationally from the queue head.
- Flush in cycle t:
  - with no request outstanding, `imem_req` to the target in t+1;
  - with a request outstanding, the new request is issued the cycle after the stale response.
- Sustained throughput is one instruction per cycle for 16-bit code at 1-cycle memory latency. For 32-bit code it is one instruction per two cycles, because requests are serialised.

## Configuration
- `FET_RV16_EN` defined: compressed support as described.
- `FET_RV16_EN` undefined:
  - queue holds words only;
  - every instruction is 32-bit and `fe2de_rv16` is tied 0;
  - `fetch_pc` steps by 4;
  - `flush_pc`[1] and `skip_lo` are ignored;
  - encodings with bits[1:0]≠2'b11 are presented unchanged, and decode flags them illegal.

## Test plan
- Reset release, `RESET_PC`=0, memory returns 32'h0000_0013 with 1-cycle latency → `imem_addr` 0,4,8…; `fet_valid` instructions 32'h13 at `fetch_pc` 0,4,8.
- Word 32'h4505_4501 at address 0 → two compressed instructions: 16'h4501 at PC 0, then 16'h4505 at PC 2, both with `fe2de_rv16`=1.
- Mixed stream: word0 = 32'h0513_4501, word1 = 32'hxxxx_0010 → c.li at PC 0, then the straddling 32-bit instruction 32'h0010_0513 at PC 2, then PC 6.
- `fet_flush` with `flush_pc`=32'h102 while a request is outstanding → stale response discarded; next request to 32'h100; its low halfword skipped; first `fet_valid` has `fetch_pc`=32'h102.
- `fet_stall` held 5 cycles with a full queue → `imem_req`=0; outputs hold the same instruction and PC; no halfword is lost after release.
- `cpurst_n` pulsed low mid-response → all outputs return to their reset values immediately; the next request is to `RESET_PC`.
